// File: rtl/io_frame_ctrl.sv
// Frame load/unload sequencer for the external bidirectional data port.
// Schedules port controls and frame-buffer address/enables; data never passes through here.
module io_frame_ctrl #(
    parameter int N_SAMPLES  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  io_clock,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic                  start_unload,
    input  logic                  abort,
    input  logic                  ext_valid,
    output logic                  c_chip_select,
    output logic                  c_ext_write,
    output logic                  c_tri_data_2b_output,
    output logic                  c_tri_data_2b_input,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  ext_strobe,
    output logic                  busy,
    output logic                  load_done,
    output logic                  unload_done
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] LOAD       = 2'd1;
    localparam logic [1:0] LOAD_FLUSH = 2'd2;
    localparam logic [1:0] UNLOAD     = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_SAMPLES - 1);

    logic [1:0]            state_r;
    logic [1:0]            state_s;
    logic [ADDR_WIDTH-1:0] cap_cnt_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic                  cap_d_r;
    logic [ADDR_WIDTH-1:0] rd_cnt_r;
    logic                  rd_act_r;
    logic                  v1_r;
    logic                  v2_r;
    logic                  load_done_r;
    logic                  unload_done_r;

    // Next-state decode; the unload ends when the last sample leaves the second valid stage
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_load) begin
                    state_s = LOAD;
                end else if (start_unload) begin
                    state_s = UNLOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (ext_valid && (cap_cnt_r == LAST_IDX)) begin
                    state_s = LOAD_FLUSH;
                end else begin
                    state_s = LOAD;
                end
            end
            LOAD_FLUSH: state_s = IDLE;
            UNLOAD: begin
                if (abort || (v2_r && !v1_r)) begin
                    state_s = IDLE;
                end else begin
                    state_s = UNLOAD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, counters, valid pipeline and done pulses
    always_ff @(posedge io_clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            cap_cnt_r     <= '0;
            wr_addr_r     <= '0;
            cap_d_r       <= 1'b0;
            rd_cnt_r      <= '0;
            rd_act_r      <= 1'b0;
            v1_r          <= 1'b0;
            v2_r          <= 1'b0;
            load_done_r   <= 1'b0;
            unload_done_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            load_done_r   <= (state_r == LOAD_FLUSH) && !abort;
            unload_done_r <= (state_r == UNLOAD) && !abort && v2_r && !v1_r;
            // Entering or leaving IDLE discards any partial progress
            if ((state_r == IDLE) || (state_s == IDLE)) begin
                cap_cnt_r <= '0;
                wr_addr_r <= '0;
                cap_d_r   <= 1'b0;
                rd_cnt_r  <= '0;
                rd_act_r  <= (state_s == UNLOAD);
                v1_r      <= 1'b0;
                v2_r      <= 1'b0;
            end else begin
                cap_d_r <= (state_r == LOAD) && ext_valid;
                if ((state_r == LOAD) && ext_valid && (cap_cnt_r != LAST_IDX)) begin
                    cap_cnt_r <= cap_cnt_r + 1'b1;
                end
                if (cap_d_r && (wr_addr_r != LAST_IDX)) begin
                    wr_addr_r <= wr_addr_r + 1'b1;
                end
                if (rd_act_r) begin
                    if (rd_cnt_r == LAST_IDX) begin
                        rd_act_r <= 1'b0;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + 1'b1;
                    end
                end
                v1_r <= rd_act_r;
                v2_r <= v1_r;
            end
        end
    end

    // Control decode from state; capture enable follows ext_valid combinationally
    always_comb begin
        c_chip_select        = 1'b0;
        c_ext_write          = 1'b0;
        c_tri_data_2b_output = 1'b1;
        c_tri_data_2b_input  = 1'b1;
        mem_addr             = '0;
        mem_we               = 1'b0;
        mem_re               = 1'b0;
        ext_strobe           = 1'b0;
        busy                 = 1'b0;
        case (state_r)
            LOAD, LOAD_FLUSH: begin
                c_chip_select       = (state_r == LOAD) ? ext_valid : 1'b0;
                c_tri_data_2b_input = !cap_d_r;
                mem_we              = cap_d_r;
                mem_addr            = cap_d_r ? wr_addr_r : '0;
                busy                = 1'b1;
            end
            UNLOAD: begin
                c_tri_data_2b_output = 1'b0;
                mem_re               = rd_act_r;
                mem_addr             = rd_act_r ? rd_cnt_r : '0;
                c_chip_select        = v1_r;
                c_ext_write          = v1_r;
                ext_strobe           = v2_r;
                busy                 = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign load_done   = load_done_r;
    assign unload_done = unload_done_r;

endmodule

// File: tb/tb_io_frame_ctrl.sv
// Self-checking bench for io_frame_ctrl: constant vector table, directed frame sequences,
// and randomized traffic compared every cycle against a cycle-count reference model.
module tb_io_frame_ctrl;
    localparam int N  = 64;
    localparam int AW = 6;

    logic          io_clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_load = 1'b0, start_unload = 1'b0, abort = 1'b0, ext_valid = 1'b0;
    logic          c_chip_select, c_ext_write, c_tri_data_2b_output, c_tri_data_2b_input;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re, ext_strobe, busy, load_done, unload_done;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    io_frame_ctrl #(.N_SAMPLES(N), .ADDR_WIDTH(AW)) dut (
        .io_clock(io_clock), .reset(reset), .start_load(start_load), .start_unload(start_unload),
        .abort(abort), .ext_valid(ext_valid), .c_chip_select(c_chip_select),
        .c_ext_write(c_ext_write), .c_tri_data_2b_output(c_tri_data_2b_output),
        .c_tri_data_2b_input(c_tri_data_2b_input), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_re(mem_re), .ext_strobe(ext_strobe), .busy(busy), .load_done(load_done),
        .unload_done(unload_done)
    );

    always #5 io_clock = ~io_clock;

    function automatic logic [15:0] pk(input logic cs, ew, tout, tin, we, re, stb, bsy, ld, ud,
                                       input logic [5:0] a);
        return {cs, ew, tout, tin, we, re, stb, bsy, ld, ud, a};
    endfunction

    logic [15:0] got;
    assign got = pk(c_chip_select, c_ext_write, c_tri_data_2b_output, c_tri_data_2b_input,
                    mem_we, mem_re, ext_strobe, busy, load_done, unload_done, mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, req);
        end
    endtask

    // Reference model: mode 0 idle, 1 load, 2 flush, 3 unload; counts captures, writes, elapsed unload cycles
    int   m_mode, m_caps, m_wrs, m_u;
    logic m_pend, m_ld, m_ud;
    always @(posedge io_clock or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_caps <= 0; m_wrs <= 0; m_u <= 0;
            m_pend <= 1'b0; m_ld <= 1'b0; m_ud <= 1'b0;
        end else begin
            m_ld <= 1'b0;
            m_ud <= 1'b0;
            case (m_mode)
                0: begin
                    if (start_load) begin
                        m_mode <= 1; m_caps <= 0; m_wrs <= 0; m_pend <= 1'b0;
                    end else if (start_unload) begin
                        m_mode <= 3; m_u <= 0;
                    end
                end
                1: begin
                    if (abort) begin
                        m_mode <= 0; m_pend <= 1'b0;
                    end else begin
                        if (m_pend) m_wrs <= m_wrs + 1;
                        m_pend <= ext_valid;
                        if (ext_valid) begin
                            m_caps <= m_caps + 1;
                            if (m_caps == N - 1) m_mode <= 2;
                        end
                    end
                end
                2: begin
                    m_mode <= 0;
                    m_pend <= 1'b0;
                    if (!abort) begin
                        m_wrs <= m_wrs + 1;
                        m_ld  <= 1'b1;
                    end
                end
                default: begin
                    if (abort) begin
                        m_mode <= 0;
                    end else if (m_u == N + 1) begin
                        m_mode <= 0; m_ud <= 1'b1;
                    end else begin
                        m_u <= m_u + 1;
                    end
                end
            endcase
        end
    end

    logic [15:0] m_exp;
    always_comb begin
        m_exp = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_ld, m_ud, 6'd0);
        case (m_mode)
            1: m_exp = pk(ext_valid, 1'b0, 1'b1, !m_pend, m_pend, 1'b0, 1'b0, 1'b1, m_ld, m_ud,
                          m_pend ? 6'(m_wrs) : 6'd0);
            2: m_exp = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, m_ld, m_ud, 6'(m_wrs));
            3: m_exp = pk((m_u >= 1) && (m_u <= N), (m_u >= 1) && (m_u <= N), 1'b0, 1'b1, 1'b0,
                          m_u < N, m_u >= 2, 1'b1, m_ld, m_ud, (m_u < N) ? 6'(m_u) : 6'd0);
            default: ;
        endcase
    end

    always @(negedge io_clock) begin
        if (chk_en) begin
            checks++;
            if (got !== m_exp) begin
                errors++;
                $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, got, m_exp);
            end
        end
    end

    // RAM holding word = address, and the port's output register
    logic [AW-1:0] ram_q = '0, port_q = '0;
    always @(posedge io_clock) begin
        if (mem_re) ram_q <= mem_addr;
        if (c_chip_select && c_ext_write) port_q <= ram_q;
    end

    typedef struct {
        logic        sl, su, ab, ev;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[7];

    task automatic cyc();
        @(posedge io_clock);
        #1;
    endtask

    task automatic load_run(input int pattern);
        int nxt = 0, wes = 0, done_at = -1;
        logic prev_ev = 1'b0;
        start_load = 1'b1;
        ext_valid  = 1'b0;
        for (int c = 0; c < 400 && done_at < 0; c++) begin
            @(negedge io_clock);
            if (mem_we) begin
                chk("we_addr_order", mem_addr, nxt);
                chk("we_after_capture", prev_ev, 1);
                nxt++;
                wes++;
            end
            if (load_done) done_at = c;
            prev_ev = ext_valid;
            cyc();
            start_load = 1'b0;
            ext_valid  = (pattern == 0) ? 1'b1 : ((c % 3) == 0);
        end
        ext_valid = 1'b0;
        chk("we_count", wes, N);
        chk("load_done_cycle", done_at, (pattern == 0) ? 66 : 192);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0)};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0)};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0)};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1)};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};

        repeat (2) cyc();
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge io_clock);
        chk("reset_state", got, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
        cyc();

        // Vector table: both starts at once, gapped captures, abort mid-write
        for (int i = 0; i < 7; i++) begin
            start_load = tbl[i].sl; start_unload = tbl[i].su;
            abort = tbl[i].ab; ext_valid = tbl[i].ev;
            @(negedge io_clock);
            chk($sformatf("table_%0d", i), got, tbl[i].exp);
            cyc();
        end
        start_load = 1'b0; start_unload = 1'b0; abort = 1'b0; ext_valid = 1'b0;
        cyc();

        load_run(0);
        cyc();
        load_run(1);
        cyc();

        // Full unload with RAM word = address
        begin
            int k = 0, first = -1, last = -1, done_at = -1;
            start_unload = 1'b1;
            for (int c = 0; c < 200 && done_at < 0; c++) begin
                @(negedge io_clock);
                if (ext_strobe) begin
                    chk("bus_data", port_q, k);
                    if (k == 0) first = c;
                    last = c;
                    k++;
                end
                if (unload_done) done_at = c;
                cyc();
                start_unload = 1'b0;
            end
            chk("strobe_count", k, N);
            chk("first_strobe", first, 3);
            chk("last_strobe", last, 66);
            chk("unload_done_cycle", done_at, 67);
        end
        cyc();

        // Abort at capture 10, then a fresh load must restart at address 0
        start_load = 1'b1;
        cyc();
        start_load = 1'b0;
        ext_valid  = 1'b1;
        repeat (9) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        ext_valid = 1'b0;
        @(negedge io_clock);
        chk("abort_busy", busy, 0);
        begin
            int ld_seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge io_clock);
                if (load_done) ld_seen++;
            end
            chk("abort_no_done", ld_seen, 0);
        end
        cyc();
        load_run(0);
        cyc();

        // Reset asserted mid-cycle at u5 of an unload
        start_unload = 1'b1;
        cyc();
        start_unload = 1'b0;
        repeat (5) cyc();
        #3;
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("reset_tri_out", c_tri_data_2b_output, 1);
        chk("reset_strobe", ext_strobe, 0);
        chk("reset_busy", busy, 0);
        cyc();
        reset = 1'b0;
        begin
            int ud_seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge io_clock);
                if (unload_done) ud_seen++;
            end
            chk("reset_no_done", ud_seen, 0);
        end
        cyc();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start_load   = ($urandom % 16) == 0;
            start_unload = ($urandom % 16) == 1;
            abort        = ($urandom % 150) == 0;
            ext_valid    = $urandom % 2;
            cyc();
        end
        start_load = 1'b0; start_unload = 1'b0; abort = 1'b0; ext_valid = 1'b0;
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
